// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between the IF and MEM requesters: round-robin
// request arbitration with grant locking, in-order responses routed via an ID FIFO.
module sram_port_arbiter #(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ID_PTR_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = ID_PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTST-1:0] fifo_q, fifo_d;
  logic                last_grant_q, last_grant_d;
  logic                lock_q, lock_d;
  logic                lock_id_q, lock_id_d;

  logic any_req, full, gnt, accept, pop, head;

  // Grant selection: a locked grant wins, otherwise round-robin on contention
  always_comb begin
    gnt = 1'b0;
    if (lock_q) begin
      gnt = lock_id_q;
    end else if (inst_req && !data_req) begin
      gnt = 1'b0;
    end else if (data_req && !inst_req) begin
      gnt = 1'b1;
    end else if (inst_req && data_req) begin
      gnt = ~last_grant_q;
    end
  end

  // Request mux, accept/response routing; all zero-latency from the shared port
  always_comb begin
    any_req      = inst_req | data_req;
    full         = (cnt_q == CNT_FULL);
    mem_req      = any_req & ~full & ~rst;
    mem_wstrb    = 4'h0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    if (any_req && !rst) begin
      mem_wstrb = gnt ? data_wstrb : inst_wstrb;
      mem_addr  = gnt ? data_addr  : inst_addr;
      mem_wdata = gnt ? data_wdata : inst_wdata;
    end
    accept       = mem_req & mem_addr_ok;
    inst_addr_ok = accept & ~gnt;
    data_addr_ok = accept & gnt;
    pop          = mem_data_ok & (cnt_q != '0);
    head         = fifo_q[rd_ptr_q];
    inst_data_ok = pop & ~head;
    data_data_ok = pop & head;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  // Next-state for occupancy, ID FIFO, round-robin history and lock
  always_comb begin
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_d       = fifo_q;
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = gnt;
      wr_ptr_d         = wr_ptr_q + ID_PTR_W'(1);
      last_grant_d     = gnt;
      lock_d           = 1'b0;
    end else if (mem_req) begin
      lock_d    = 1'b1;
      lock_id_d = gnt;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ID_PTR_W'(1);
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_q       <= '0;
      last_grant_q <= 1'b0;
      lock_q       <= 1'b0;
      lock_id_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_q       <= fifo_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage). It is the stepping stone towards a single-port / AXI bridge.
- Request phase (req/addr_ok): round-robin arbitration with grant locking.
- Response phase (data_ok): returned in order, routed to the issuing master through an ID FIFO.
- Supports up to MAX_OUTST outstanding transactions.

Parameters:
MAX_OUTST, 4, max accepted-but-unanswered transactions (power of 2, ≥2)
ID_PTR_W, 2, log2(MAX_OUTST), FIFO pointer width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
inst_req  in  1  IF request valid
inst_wstrb  in  4  IF byte write strobe (0 = read)
inst_addr  in  32  IF address
inst_wdata  in  32  IF write data
inst_addr_ok  out  1  IF request accepted this cycle
inst_data_ok  out  1  IF response valid this cycle
inst_rdata  out  32  IF read data
data_req  in  1  MEM request valid
data_wstrb  in  4  MEM byte write strobe (0 = read)
data_addr  in  32  MEM address
data_wdata  in  32  MEM write data
data_addr_ok  out  1  MEM request accepted this cycle
data_data_ok  out  1  MEM response valid this cycle
data_rdata  out  32  MEM read data
mem_req  out  1  request to shared port
mem_wstrb  out  4  muxed strobe
mem_addr  out  32  muxed address
mem_wdata  out  32  muxed write data
mem_addr_ok  in  1  shared port accepted request
mem_data_ok  in  1  shared port response valid (in order)
mem_rdata  in  32  shared port read data

Behaviour:
- **Reset (async, rst=1):**
  - cnt=0; FIFO rd/wr ptr=0; last_grant=0 (inst); lock=0; lock_id=0.
  - All outputs low or zero except the rdata pass-throughs.
- **State:**
  - cnt: 0..MAX_OUTST.
  - full = (cnt==MAX_OUTST).
  - FIFO: MAX_OUTST×1 bit, where 0=inst and 1=data.
- **Grant (combinational):**
  - If lock=1, gnt=lock_id.
  - Else if exactly one req is high, gnt is that master.
  - Else if both are high, gnt = ~last_grant.
- **Request drive:**
  - mem_req = (inst_req|data_req) & ~full.
  - mem_wstrb/addr/wdata are muxed by gnt.
  - Fields are zero when no req is high.
- **Accept:**
  - accept = mem_req & mem_addr_ok.
  - The granted master's addr_ok = accept; the other master's addr_ok = 0.
  - On accept: push gnt, last_grant←gnt, lock←0.
- **Lock:**
  - If mem_req & ~mem_addr_ok, then lock←1 and lock_id←gnt.
  - This keeps the presented request stable until accepted.
  - Masters hold req and fields stable until addr_ok.
- **Full:**
  - mem_req is forced to 0 while full, even if a response pops in the same cycle; issue resumes the next cycle.
  - A lock, if held, persists across the full stall.
- **Response:**
  - On mem_data_ok with cnt>0, assert data_ok to the master at the FIFO head, then pop.
  - inst_rdata = data_rdata = mem_rdata, both unconditional pass-through.
  - Writes also receive data_ok; rdata is don't-care for writes.
- **Spurious response:** mem_data_ok with cnt==0 is ignored: no data_ok, no pop, cnt stays 0.
- **Counter update:**
  - push & pop in the same cycle: cnt unchanged, both pointers advance.
  - push only: cnt+1. pop only: cnt−1.
  - Pointers wrap modulo MAX_OUTST.
- **Latency:** 0 added cycles in each direction. addr_ok and data_ok are combinational from mem_addr_ok and mem_data_ok.
- **Reset mid-operation:** all in-flight IDs are discarded. Any later mem_data_ok is handled by the spurious-response rule.

Test Plan:
1. **Single read:** inst_req=1, inst_addr=0x1C000000, mem_addr_ok=1, then mem_data_ok=1 with rdata=0xDEADBEEF → inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=0xDEADBEEF; cnt returns to 0.
2. **Contention after reset:** both reqs high, mem_addr_ok=1 for 2 cycles → data granted first (last_grant=inst), inst second; mem_addr sequence is data_addr then inst_addr.
3. **Lock:** inst granted with mem_addr_ok=0 for 3 cycles while data_req rises in cycle 1 → mem_addr stays inst_addr until acceptance; data is accepted next.
4. **Full:** MAX_OUTST=4, issue 4 requests with no response → mem_req=0 on the 5th. A mem_data_ok in the full cycle pops, and mem_req reasserts the following cycle.
5. **Ordering:** issue inst, data, inst, then 3 mem_data_ok → inst_data_ok, data_data_ok, inst_data_ok in that order. Pointer wrap is checked after 8 transactions.
6. **Spurious and reset:** mem_data_ok with cnt=0 → no data_ok pulse. Asserting rst with 2 outstanding → cnt=0 immediately (async), and outputs go to zero.
